sad_window_generator: RTL and testbench
=======================================

// Module: sad_window_generator
// PURPOSE
//  Producer of (window_sum, disparity) candidates for the disparity-select comparator stage.
//  Accepts a stream of left/right pixel pairs.
//  For each disparity it accumulates |L-R| over one WIN_SAMPLES-pixel window.
//  It then emits the registered window sum tagged with its disparity index.
//  Sweeps disparity 0..MAX_DISP-1 per start pulse, with ready/valid on both sides.
// PARAMETERS
//  PIX_W       8   pixel width, bits
//  WIN_SAMPLES 49  absolute differences summed per window (7x7)
//  MAX_DISP    64  disparities per sweep; must be <= 2**DISP_W
//  SUM_W       14  window_sum width
//  DISP_W      6   disparity width
// PORTS
//  clock       in   1       system clock, rising edge
//  reset_n     in   1       asynchronous, active-low reset
//  start       in   1       single-cycle pulse, begins a disparity sweep (IDLE only)
//  pix_valid   in   1       pix_left/pix_right valid
//  pix_ready   out  1       block accepts a pixel pair this cycle
//  pix_left    in   PIX_W   left-image pixel
//  pix_right   in   PIX_W   right-image pixel (already shifted by current disparity)
//  out_valid   out  1       window_sum/disparity/disp_last valid
//  out_ready   in   1       downstream accepts the candidate
//  window_sum  out  SUM_W   SAD of the completed window
//  disparity   out  DISP_W  disparity index of window_sum
//  disp_last   out  1       candidate is disparity MAX_DISP-1
//  busy        out  1       sweep in progress (state != IDLE)
// BEHAVIOUR
//  Reset: all outputs 0; state IDLE; accumulator, sample counter and disparity counter 0.
//  Outputs are registered; pix_ready and busy decode from state.
//  FSM IDLE: pix_ready=0, out_valid=0.
//   - On start=1: clear acc, samp_cnt and disp_cnt, then go to ACCUM.
//  FSM ACCUM: pix_ready=1.
//   - Each handshake (pix_valid&pix_ready) adds |pix_left-pix_right| to acc and increments samp_cnt.
//   - Idle cycles (pix_valid=0) change nothing.
//   - On the handshake where samp_cnt==WIN_SAMPLES-1, the next edge loads:
//     window_sum=acc+ad, disparity=disp_cnt, disp_last=(disp_cnt==MAX_DISP-1), out_valid=1.
//     State then goes to EMIT.
//   - Latency: out_valid is high 1 cycle after the last pixel of the window is accepted.
//  FSM EMIT: pix_ready=0; outputs held stable until out_valid&out_ready.
//   - On the handshake with disp_last=1: go to IDLE; out_valid and disp_last clear next cycle.
//   - Otherwise: disp_cnt++, clear acc and samp_cnt, go to ACCUM; out_valid=0 next cycle.
//   - With out_ready tied high, throughput is one window per WIN_SAMPLES+1 accepting cycles.
//  Arithmetic:
//   - |L-R| is an unsigned PIX_W-bit value.
//   - acc is SUM_W+1 bits internally; the output handling is set by the macro below.
//  start is ignored outside IDLE. start in the same cycle as the final EMIT handshake is ignored.
//  Reset mid-operation aborts the sweep immediately. No partial candidate is emitted.
// CONFIGURATION
//  SAD_SATURATE_EN defined: the sum clamps at 2**SUM_W-1 (16383).
//   - Once clamped, further additions keep it clamped.
//  SAD_SATURATE_EN undefined: the sum wraps modulo 2**SUM_W.
//  With the defaults (49*255=12495) both builds give the same result.
// TESTING
//  1. start; 49 pairs L=10,R=3 -> window_sum=343, disparity=0, out_valid 1 cycle after 49th accept.
//  2. Hold out_ready=0 for 5 cycles in EMIT.
//     -> outputs stable, pix_ready=0.
//     -> after the handshake, the next window reports disparity=1.
//  3. Full sweep, 64 windows of L=R, out_ready=1.
//     -> sums 0, disparity 0..63.
//     -> disp_last only on 63; busy=0 the cycle after the last handshake.
//  4. WIN_SAMPLES=81, L=255,R=0.
//     -> window_sum=16383 with SAD_SATURATE_EN.
//     -> window_sum=4271 (20655 mod 16384) without it.
//  5. reset_n low after 20 samples in ACCUM -> all outputs 0, IDLE.
//     Then a new start with 49 pairs of diff 1 -> window_sum=49.
//  6. pix_valid toggling every other cycle, plus start pulsed during ACCUM.
//     -> sum identical to the gap-free case; disp_cnt not reset.

Source files
------------

// File: rtl/sad_window_generator.sv
// Streams |L-R| over WIN_SAMPLES-pixel windows per disparity; emits (window_sum, disparity) candidates.
// Latency: out_valid 1 cycle after the last pixel of a window; backpressure holds outputs, pix_ready low in EMIT.
// Build option SAD_SATURATE_EN: clamp the sum at 2**SUM_W-1 instead of wrapping modulo 2**SUM_W.
module sad_window_generator #(
    parameter int PIX_W       = 8,
    parameter int WIN_SAMPLES = 49,
    parameter int MAX_DISP    = 64,
    parameter int SUM_W       = 14,
    parameter int DISP_W      = 6
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              start,
    input  logic              pix_valid,
    output logic              pix_ready,
    input  logic [PIX_W-1:0]  pix_left,
    input  logic [PIX_W-1:0]  pix_right,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [SUM_W-1:0]  window_sum,
    output logic [DISP_W-1:0] disparity,
    output logic              disp_last,
    output logic              busy
);

    localparam int SAMP_W = $clog2(WIN_SAMPLES + 1);
    localparam logic [SAMP_W-1:0] SAMP_LAST = SAMP_W'(WIN_SAMPLES - 1);
    localparam logic [DISP_W-1:0] DISP_LAST = DISP_W'(MAX_DISP - 1);

    typedef enum logic [1:0] {IDLE, ACCUM, EMIT} state_t;

    state_t            state;
    logic [SUM_W:0]    acc;
    logic [SAMP_W-1:0] samp_cnt;
    logic [DISP_W-1:0] disp_cnt;
    logic [PIX_W-1:0]  abs_diff;
    logic [SUM_W:0]    acc_next;

    assign pix_ready = (state == ACCUM);
    assign busy      = (state != IDLE);

    always_comb begin
        abs_diff = (pix_left >= pix_right) ? (pix_left - pix_right) : (pix_right - pix_left);
        acc_next = acc + (SUM_W + 1)'(abs_diff);
`ifdef SAD_SATURATE_EN
        // acc never exceeds the clamp value, so the SUM_W+1 bit add cannot overflow
        if (acc_next > (SUM_W + 1)'((2 ** SUM_W) - 1))
            acc_next = (SUM_W + 1)'((2 ** SUM_W) - 1);
`endif
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state      <= IDLE;
            acc        <= '0;
            samp_cnt   <= '0;
            disp_cnt   <= '0;
            out_valid  <= 1'b0;
            window_sum <= '0;
            disparity  <= '0;
            disp_last  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        acc      <= '0;
                        samp_cnt <= '0;
                        disp_cnt <= '0;
                        state    <= ACCUM;
                    end
                end
                ACCUM: begin
                    if (pix_valid) begin
                        if (samp_cnt == SAMP_LAST) begin
                            window_sum <= acc_next[SUM_W-1:0];
                            disparity  <= disp_cnt;
                            disp_last  <= (disp_cnt == DISP_LAST);
                            out_valid  <= 1'b1;
                            state      <= EMIT;
                        end else begin
                            acc      <= acc_next;
                            samp_cnt <= samp_cnt + 1'b1;
                        end
                    end
                end
                EMIT: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        if (disp_last) begin
                            disp_last <= 1'b0;
                            state     <= IDLE;
                        end else begin
                            disp_cnt <= disp_cnt + 1'b1;
                            acc      <= '0;
                            samp_cnt <= '0;
                            state    <= ACCUM;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_sad_window_generator.sv
// Directed bench for sad_window_generator: default instance plus an 81-sample instance for sum overflow.
module tb_sad_window_generator;

    logic        clock = 1'b0;
    logic        reset_n;
    logic        start, pix_valid, pix_ready, out_valid, out_ready, disp_last, busy;
    logic [7:0]  pix_left, pix_right;
    logic [13:0] window_sum;
    logic [5:0]  disparity;

    logic        start2, pix_valid2, pix_ready2, out_valid2, out_ready2, disp_last2, busy2;
    logic [7:0]  pix_left2, pix_right2;
    logic [13:0] window_sum2;
    logic [5:0]  disparity2;

    int checks = 0;
    int failures = 0;

    always #5 clock = ~clock;

    sad_window_generator dut (
        .clock(clock), .reset_n(reset_n), .start(start),
        .pix_valid(pix_valid), .pix_ready(pix_ready),
        .pix_left(pix_left), .pix_right(pix_right),
        .out_valid(out_valid), .out_ready(out_ready),
        .window_sum(window_sum), .disparity(disparity),
        .disp_last(disp_last), .busy(busy)
    );

    sad_window_generator #(.WIN_SAMPLES(81), .MAX_DISP(1)) dut81 (
        .clock(clock), .reset_n(reset_n), .start(start2),
        .pix_valid(pix_valid2), .pix_ready(pix_ready2),
        .pix_left(pix_left2), .pix_right(pix_right2),
        .out_valid(out_valid2), .out_ready(out_ready2),
        .window_sum(window_sum2), .disparity(disparity2),
        .disp_last(disp_last2), .busy(busy2)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    // Presents n pairs (l, r); optional idle gap and start pulse between accepted pairs.
    task automatic feed(input logic [7:0] l, input logic [7:0] r, input int n, input bit gap);
        for (int i = 0; i < n; i++) begin
            int t = 0;
            pix_left  = l;
            pix_right = r;
            pix_valid = 1'b1;
            start     = gap;
            while (!pix_ready && t < 200) begin
                step();
                t++;
            end
            if (t == 200) check("pix_ready_timeout", 0, 1);
            step();
            pix_valid = 1'b0;
            start     = 1'b0;
            if (gap && i < n - 1) step();
        end
    endtask

    task automatic pulse_start();
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    initial begin
        reset_n = 1'b0;
        start = 0; pix_valid = 0; pix_left = 0; pix_right = 0; out_ready = 0;
        start2 = 0; pix_valid2 = 0; pix_left2 = 0; pix_right2 = 0; out_ready2 = 0;
        step();
        check("rst_out_valid", out_valid, 0);
        check("rst_window_sum", window_sum, 0);
        check("rst_disparity", disparity, 0);
        check("rst_disp_last", disp_last, 0);
        check("rst_busy", busy, 0);
        check("rst_pix_ready", pix_ready, 0);
        reset_n = 1'b1;
        step();

        // 81 x |255-0| = 20655 exceeds the 14-bit sum
        start2 = 1'b1;
        step();
        start2 = 1'b0;
        pix_valid2 = 1'b1; pix_left2 = 8'd255; pix_right2 = 8'd0;
        repeat (81) step();
        pix_valid2 = 1'b0;
        check("w81_out_valid", out_valid2, 1);
`ifdef SAD_SATURATE_EN
        check("w81_sum", window_sum2, 16383);
`else
        check("w81_sum", window_sum2, 4271);
`endif
        check("w81_disp_last", disp_last2, 1);

        // window 0: 49 x |10-3| = 343
        pulse_start();
        check("start_busy", busy, 1);
        check("start_pix_ready", pix_ready, 1);
        feed(8'd10, 8'd3, 48, 1'b0);
        check("pre_last_out_valid", out_valid, 0);
        feed(8'd10, 8'd3, 1, 1'b0);
        check("w0_out_valid", out_valid, 1);
        check("w0_sum", window_sum, 343);
        check("w0_disparity", disparity, 0);
        check("w0_disp_last", disp_last, 0);
        check("w0_pix_ready", pix_ready, 0);

        for (int i = 0; i < 5; i++) begin
            step();
            check("hold_out_valid", out_valid, 1);
            check("hold_sum", window_sum, 343);
            check("hold_disparity", disparity, 0);
            check("hold_pix_ready", pix_ready, 0);
        end
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        check("emit_done_out_valid", out_valid, 0);
        check("emit_done_pix_ready", pix_ready, 1);

        // window 1 with gaps and start pulses during ACCUM
        feed(8'd3, 8'd10, 49, 1'b1);
        check("gap_out_valid", out_valid, 1);
        check("gap_sum", window_sum, 343);
        check("gap_disparity", disparity, 1);
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;

        // reset mid-window
        feed(8'd200, 8'd0, 20, 1'b0);
        reset_n = 1'b0;
        #2;
        check("abort_busy", busy, 0);
        check("abort_pix_ready", pix_ready, 0);
        check("abort_out_valid", out_valid, 0);
        check("abort_sum", window_sum, 0);
        check("abort_disparity", disparity, 0);
        step();
        reset_n = 1'b1;
        step();
        pulse_start();
        feed(8'd4, 8'd5, 49, 1'b0);
        check("after_abort_sum", window_sum, 49);
        check("after_abort_disparity", disparity, 0);

        // full sweep of L=R
        reset_n = 1'b0;
        step();
        reset_n = 1'b1;
        step();
        pulse_start();
        out_ready = 1'b1;
        for (int d = 0; d < 64; d++) begin
            feed(8'd77, 8'd77, 49, 1'b0);
            check("sweep_out_valid", out_valid, 1);
            check("sweep_sum", window_sum, 0);
            check("sweep_disparity", disparity, d);
            check("sweep_disp_last", disp_last, (d == 63) ? 1 : 0);
            if (d == 63) start = 1'b1;
            step();
            start = 1'b0;
        end
        check("sweep_end_busy", busy, 0);
        check("sweep_end_out_valid", out_valid, 0);
        check("sweep_end_disp_last", disp_last, 0);
        step();
        check("sweep_start_ignored", busy, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
